snn_spike_decoder: RTL and testbench

//   Output-side decoder for the SNN core: counts spikes on each output neuron line over a

---
 rtl/snn_spike_decoder.sv | 138 +++++++++++++
 tb/tb_snn_spike_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/snn_spike_decoder.sv
`default_nettype none
// snn_spike_decoder: windowed per-neuron saturating spike counters, sequential argmax, valid/ready result.
// Optional macro SNN_DEC_CNTREAD_EN adds cnt_sel/cnt_rd counter readback.  Rev 1.0
module snn_spike_decoder #(
  parameter  int N_OUT = 8,
  parameter  int CNT_W = 8,
  parameter  int WIN_W = 16,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [N_OUT-1:0] spk_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] winner,
  output logic [CNT_W-1:0] winner_count,
  output logic             tie
`ifdef SNN_DEC_CNTREAD_EN
  ,
  input  logic [IDX_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_rd
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt [N_OUT];
  logic [WIN_W-1:0] win_left;
  logic [IDX_W:0]   scan_idx;
  logic [IDX_W-1:0] scan_sel;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_done;
  logic             win_last;
  logic [CNT_W-1:0] best_cnt;
  logic [IDX_W-1:0] best_idx;
  logic             best_tie;

  // The scan step with scan_idx == N_OUT only commits the result; no neuron is read.
  assign scan_done = (scan_idx == (IDX_W+1)'(N_OUT));
  assign scan_sel  = scan_idx[IDX_W-1:0];
  assign scan_cnt  = cnt[scan_sel];
  assign win_last  = (win_left == WIN_W'(1));

  assign busy         = (state == ST_COUNT) || (state == ST_ARGMAX);
  assign result_valid = (state == ST_DONE);

`ifdef SNN_DEC_CNTREAD_EN
  assign cnt_rd = ({1'b0, cnt_sel} < (IDX_W+1)'(N_OUT)) ? cnt[cnt_sel] : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)        state_nxt = ST_COUNT;
      ST_COUNT:  if (win_last)     state_nxt = ST_ARGMAX;
      ST_ARGMAX: if (scan_done)    state_nxt = ST_DONE;
      ST_DONE:   if (result_ready) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        cnt[i] <= '0;
      end
      win_left     <= '0;
      scan_idx     <= '0;
      best_cnt     <= '0;
      best_idx     <= '0;
      best_tie     <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_OUT; i++) begin
              cnt[i] <= '0;
            end
            win_left <= (window_len == '0) ? WIN_W'(1) : window_len;
            scan_idx <= '0;
            best_cnt <= '0;
            best_idx <= '0;
            best_tie <= 1'b0;
          end
        end
        ST_COUNT: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (spk_in[i] && (cnt[i] != {CNT_W{1'b1}})) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          win_left <= win_left - WIN_W'(1);
        end
        ST_ARGMAX: begin
          if (!scan_done) begin
            // Strict compare keeps the lowest index on equal counts.
            if (scan_cnt > best_cnt) begin
              best_cnt <= scan_cnt;
              best_idx <= scan_sel;
              best_tie <= 1'b0;
            end else if ((scan_cnt == best_cnt) && (scan_idx != '0)) begin
              best_tie <= 1'b1;
            end
            scan_idx <= scan_idx + (IDX_W+1)'(1);
          end else begin
            winner       <= best_idx;
            winner_count <= best_cnt;
            tie          <= best_tie;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_spike_decoder.sv
`default_nettype none
// Randomized bench for snn_spike_decoder with a per-window counting/argmax reference model.
module tb_snn_spike_decoder;

  localparam int N_OUT = 8;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int IDX_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic [N_OUT-1:0] spk_in;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] winner_count;
  logic             tie;
`ifdef SNN_DEC_CNTREAD_EN
  logic [IDX_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_rd;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt [N_OUT];
  int e_win, e_cnt, e_tie;

  always #5 clk = ~clk;

  snn_spike_decoder #(.N_OUT(N_OUT), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .window_len   (window_len),
    .spk_in       (spk_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .winner       (winner),
    .winner_count (winner_count),
    .tie          (tie)
`ifdef SNN_DEC_CNTREAD_EN
    ,
    .cnt_sel      (cnt_sel),
    .cnt_rd       (cnt_rd)
`endif
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N_OUT-1:0] pattern(input int mode, input int k);
    case (mode)
      1: return 8'h08;
      2: return (k < 3) ? (8'h24 | ((k == 0) ? 8'h01 : ((k == 1) ? 8'h80 : 8'h00))) : 8'h00;
      3: return 8'h80;
      4: return (k == 0) ? 8'h01 : 8'h00;
      5: return 8'h00;
      6: return 8'hFF;
      default: return 8'($urandom) & 8'($urandom);
    endcase
  endfunction

  task automatic check_result(input string tag);
    check_val({tag, "_winner"}, int'(winner), e_win);
    check_val({tag, "_count"},  int'(winner_count), e_cnt);
    check_val({tag, "_tie"},    int'(tie), e_tie);
  endtask

  // Entered and left on a falling edge.
  task automatic run_decode(input int wl, input int mode, input int hold);
    int w, c, mx, nmax;
    w = (wl == 0) ? 1 : wl;
    for (int i = 0; i < N_OUT; i++) exp_cnt[i] = 0;
    window_len = WIN_W'(wl);
    start      = 1'b1;
    spk_in     = 8'($urandom);
    @(negedge clk);
    start      = 1'b0;
    window_len = WIN_W'($urandom);
    c = 0;
    check_val("busy_count", int'(busy), 1);
    for (int k = 0; k < w; k++) begin
      spk_in = pattern(mode, k);
      for (int i = 0; i < N_OUT; i++)
        if (spk_in[i] && exp_cnt[i] < CMAX) exp_cnt[i]++;
      @(negedge clk);
      c++;
    end
    spk_in = 8'($urandom);
    while (!result_valid && c < w + N_OUT + 40) begin
      @(negedge clk);
      c++;
      spk_in = 8'($urandom);
    end
    check_val("latency", c, w + N_OUT + 1);
    check_val("busy_done", int'(busy), 0);

    mx = 0;
    for (int i = 0; i < N_OUT; i++) if (exp_cnt[i] > mx) mx = exp_cnt[i];
    e_win = -1;
    nmax  = 0;
    for (int i = 0; i < N_OUT; i++)
      if (exp_cnt[i] == mx) begin
        nmax++;
        if (e_win < 0) e_win = i;
      end
    e_cnt = mx;
    e_tie = (nmax > 1) ? 1 : 0;
    check_result("res");

`ifdef SNN_DEC_CNTREAD_EN
    for (int i = 0; i < N_OUT; i++) begin
      cnt_sel = IDX_W'(i);
      #1;
      check_val("cnt_rd", int'(cnt_rd), exp_cnt[i]);
    end
`endif

    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (h == hold / 2) start = 1'b1;
      window_len = WIN_W'($urandom);
      @(negedge clk);
      start = 1'b0;
      check_val("hold_valid", int'(result_valid), 1);
      check_result("hold");
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check_val("ack_valid", int'(result_valid), 0);
    check_val("ack_busy", int'(busy), 0);
    check_result("idle_hold");
  endtask

  task automatic reset_mid_count();
    window_len = WIN_W'(50);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      spk_in = 8'($urandom);
      @(negedge clk);
    end
    check_val("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_valid", int'(result_valid), 0);
    check_val("arst_winner", int'(winner), 0);
    check_val("arst_count", int'(winner_count), 0);
    check_val("arst_tie", int'(tie), 0);
`ifdef SNN_DEC_CNTREAD_EN
    cnt_sel = IDX_W'(0);
    #1;
    check_val("arst_cnt_rd", int'(cnt_rd), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_busy", int'(busy), 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    window_len   = '0;
    spk_in       = '0;
`ifdef SNN_DEC_CNTREAD_EN
    cnt_sel      = '0;
`endif
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(result_valid), 0);
    check_val("rst_winner", int'(winner), 0);
    check_val("rst_count", int'(winner_count), 0);
    check_val("rst_tie", int'(tie), 0);
    reset = 1'b0;
    @(negedge clk);

    run_decode(10, 1, 0);
    run_decode(4, 2, 3);
    run_decode(300, 3, 0);
    run_decode(0, 4, 0);
    reset_mid_count();
    run_decode(7, 0, 1);
    run_decode(6, 5, 0);
    run_decode(10, 1, 20);
    run_decode(5, 6, 2);
    repeat (12) run_decode(int'($urandom_range(1, 30)), 0, int'($urandom_range(0, 4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
